// File: rtl/serial_paralelo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_paralelo_pkg
//  Description : Shared constants and lane-state encoding for the receive-side
//                deserializer.
//  Revision    : 1.0
// ============================================================================
package serial_paralelo_pkg;

    localparam logic [7:0] COM_SYMBOL = 8'hBC;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } lane_state_t;

endpackage
`default_nettype wire

// File: rtl/serial_shift_aligner.sv
`default_nettype none
// ============================================================================
//  Module      : serial_shift_aligner
//  Description : Bit-clock shift register and COM-based byte aligner; hands
//                each completed byte to the byte-clock domain with a toggle.
//  Revision    : 1.0
// ============================================================================
module serial_shift_aligner
    import serial_paralelo_pkg::*;
(
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    input  logic       realign,
    output logic       aligned,
    output logic [7:0] byte_hold,
    output logic       byte_tgl
);

    logic [7:0] r_shift_reg;
    logic [2:0] r_bit_cnt;
    logic       r_aligned;
    logic [7:0] r_byte_hold;
    logic       r_byte_tgl;
    logic [7:0] w_shift_next;

    always_comb begin
        w_shift_next = {r_shift_reg[6:0], data_in};
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            r_shift_reg <= 8'h00;
            r_bit_cnt   <= 3'd0;
            r_aligned   <= 1'b0;
            r_byte_hold <= 8'h00;
            r_byte_tgl  <= 1'b0;
        end else begin
            r_shift_reg <= w_shift_next;
            if (realign) begin
                r_aligned <= 1'b0;
            end else if (!r_aligned) begin
                if (w_shift_next == COM_SYMBOL) begin
                    r_aligned   <= 1'b1;
                    r_bit_cnt   <= 3'd0;
                    r_byte_hold <= w_shift_next;
                    r_byte_tgl  <= ~r_byte_tgl;
                end
            end else begin
                // Byte boundary is the wrap of the 3-bit counter.
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    r_byte_hold <= w_shift_next;
                    r_byte_tgl  <= ~r_byte_tgl;
                end
            end
        end
    end

    assign aligned   = r_aligned;
    assign byte_hold = r_byte_hold;
    assign byte_tgl  = r_byte_tgl;

endmodule
`default_nettype wire

// File: rtl/serial_paralelo.sv
`default_nettype none
// ============================================================================
//  Module      : serial_paralelo
//  Description : Receive-side deserializer: aligns the MSB-first lane on COM,
//                locks after a run of COMs and forwards non-COM bytes.
//  Revision    : 1.0
// ============================================================================
module serial_paralelo
    import serial_paralelo_pkg::*;
#(
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic       clk_4f,
    input  logic       reset,
    input  logic       clk_32f,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
);

    localparam logic [3:0] c_lock_count = 4'(LOCK_COUNT);

    logic        w_aligned;
    logic [7:0]  w_byte_hold;
    logic        w_byte_tgl;

    logic        r_tgl_seen;
    logic        r_new;
    logic [7:0]  r_byte;
    logic        r_aligned;
    logic        r_realign;

    lane_state_t r_state;
    lane_state_t w_state_next;
    logic [3:0]  r_com_cnt;
    logic [3:0]  w_com_cnt_next;
    logic        w_realign_next;

    logic [7:0]  r_data_out;
    logic        r_valid_out;
    logic        r_active;

    serial_shift_aligner u_aligner (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .data_in   (data_in),
        .realign   (r_realign),
        .aligned   (w_aligned),
        .byte_hold (w_byte_hold),
        .byte_tgl  (w_byte_tgl)
    );

    // Clocks share a source, and byte_hold is stable for a full byte period,
    // so one sampling stage is enough.
    always_ff @(posedge clk_4f) begin
        if (reset) begin
            r_tgl_seen <= 1'b0;
            r_new      <= 1'b0;
            r_byte     <= 8'h00;
            r_aligned  <= 1'b0;
        end else begin
            r_tgl_seen <= w_byte_tgl;
            r_new      <= (w_byte_tgl != r_tgl_seen);
            r_byte     <= w_byte_hold;
            r_aligned  <= w_aligned;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_com_cnt_next = r_com_cnt;
        w_realign_next = 1'b0;
        if (r_new) begin
            case (r_state)
                HUNT: begin
                    // A byte captured just before a realign took effect is stale.
                    if (r_aligned && !r_realign && (r_byte == COM_SYMBOL)) begin
                        w_com_cnt_next = 4'd1;
                        w_state_next   = (c_lock_count == 4'd1) ? ACTIVE : ALIGN;
                    end
                end
                ALIGN: begin
                    if (r_byte == COM_SYMBOL) begin
                        w_com_cnt_next = r_com_cnt + 4'd1;
                        if ((r_com_cnt + 4'd1) == c_lock_count) begin
                            w_state_next = ACTIVE;
                        end
                    end else begin
                        w_com_cnt_next = 4'd0;
                        w_realign_next = 1'b1;
                        w_state_next   = HUNT;
                    end
                end
                ACTIVE: begin
                    w_state_next = ACTIVE;
                end
                default: begin
                    w_state_next = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            r_state     <= HUNT;
            r_com_cnt   <= 4'd0;
            r_realign   <= 1'b0;
            r_data_out  <= 8'h00;
            r_valid_out <= 1'b0;
            r_active    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_com_cnt   <= w_com_cnt_next;
            r_realign   <= w_realign_next;
            r_active    <= (w_state_next == ACTIVE);
            r_valid_out <= 1'b0;
            if (r_new && (r_state == ACTIVE) && (r_byte != COM_SYMBOL)) begin
                r_data_out  <= r_byte;
                r_valid_out <= 1'b1;
            end
        end
    end

    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;
    assign active    = r_active;

endmodule
`default_nettype wire
